ram_port_arbiter: RTL
=====================

Name: ram_port_arbiter

Overview:
Shares the single cache-to-RAM interface controller between two cache requesters: port 0 (instruction cache, read-only in practice) and port 1 (data cache, read/write).
Sits between both caches and the interface controller. Arbitrates round-robin, registers the winning request and holds it stable for the whole transaction. Returns the one-cycle ack to the granted requester only.
Drives grant_id so the read-data and write-data datapaths can be steered.

Parameters:
ADDR_SIZE, 13, width of request/RAM address
CACHE_STR_WIDTH, 64, width of cache-line write data
TIMEOUT_CYCLES, 255, S_WAIT cycles before watchdog abort (used only with RAM_ARB_TIMEOUT_EN); 8-bit counter, legal range 1..255

Ports:
clk  in  1  clock
not_reset  in  1  reset, asynchronous, active-low
req0_avalid  in  1  port 0 request valid (level, held until req0_ack)
req0_addr  in  ADDR_SIZE  port 0 address
req0_rnw  in  1  port 0 1=read 0=write
req0_wdata  in  CACHE_STR_WIDTH  port 0 write line
req0_ack  out  1  port 0 completion pulse
req1_avalid  in  1  port 1 request valid
req1_addr  in  ADDR_SIZE  port 1 address
req1_rnw  in  1  port 1 direction
req1_wdata  in  CACHE_STR_WIDTH  port 1 write line
req1_ack  out  1  port 1 completion pulse
ctrl_avalid  out  1  request pulse to interface controller
ctrl_addr  out  ADDR_SIZE  registered address to controller
ctrl_rnw  out  1  registered direction to controller
ctrl_wdata  out  CACHE_STR_WIDTH  registered write line to controller
ctrl_ack  in  1  controller completion pulse (reads and writes)
grant_id  out  1  owning port, valid while busy=1
busy  out  1  transaction in flight
timeout_err  out  1  watchdog abort pulse (0 when feature off)

Behaviour:
- Reset: state S_IDLE. All outputs 0: ctrl_addr, ctrl_wdata, ctrl_rnw, ctrl_avalid, req*_ack, grant_id, busy, timeout_err. Internal last_grant=1, so port 0 wins the first tie. Reset mid-transaction drops everything immediately; the controller is reset by the same not_reset.
- States: S_IDLE -> S_ISSUE -> S_WAIT -> S_RESP -> S_IDLE. All outputs registered.
- S_IDLE:
  - One requester valid: grant it.
  - Both valid: grant the port != last_grant.
  - On grant: latch addr/rnw/wdata into ctrl_*, set grant_id, last_grant, busy=1; go to S_ISSUE.
- S_ISSUE: ctrl_avalid=1 for exactly one cycle; go to S_WAIT.
- S_WAIT:
  - ctrl_avalid=0. ctrl_addr/rnw/wdata stay constant; the controller re-samples them after avalid.
  - On ctrl_ack=1: go to S_RESP.
- S_RESP:
  - reqN_ack=1 for one cycle, N=grant_id. Other ack stays 0.
  - Next cycle: acks 0, busy 0, state S_IDLE.
- Requester rule: avalid must be low by the clock edge that samples its ack=1. The requester may re-raise avalid one cycle later.
- Minimum issue spacing: 4 cycles grant-to-grant plus controller latency. No back-to-back avalid to the controller.
- Requester input changes while not in S_IDLE are ignored. A request arriving during busy waits; it is not dropped.
- ctrl_ack outside S_WAIT is ignored.
- Simultaneous arrival of both requests in S_IDLE resolves by last_grant.
- Starvation bound: with both ports continuously requesting, grants alternate strictly.

Optional Feature:
RAM_ARB_TIMEOUT_EN
- Defined: 8-bit counter clears on entry to S_WAIT and increments each S_WAIT cycle. When count==TIMEOUT_CYCLES without ctrl_ack, go to S_RESP and pulse timeout_err together with reqN_ack. A late ctrl_ack is then ignored.
- Undefined: no counter; S_WAIT waits indefinitely; timeout_err tied 0.

Decomposition:
- Package ram_arb_pkg: state encoding localparams (S_IDLE=0, S_ISSUE=1, S_WAIT=2, S_RESP=3, 2-bit), port ID constants PORT_ICACHE=0, PORT_DCACHE=1.
- Sub-module rr_arb2: combinational 2-way round-robin pick from (req0, req1, last_grant). Outputs grant_valid and grant_id.

Test Plan:
- Single read: req0 addr=0x0123 rnw=1; ctrl_ack 10 cycles after ctrl_avalid -> one ctrl_avalid pulse; ctrl_addr=0x0123 held until ack; req0_ack one cycle; req1_ack never asserted.
- Simultaneous: both avalid same cycle after reset -> port 0 served first, port 1 second. Both held continuously for 3 rounds -> grant order 0,1,0,1,0,1.
- Write path: req1 rnw=0 wdata=0xDEADBEEF_CAFEF00D, addr=0x1FFF -> ctrl_wdata and ctrl_addr stable from ISSUE through RESP; req1_ack after ctrl_ack.
- Busy contention: req0 arrives while port 1 is in S_WAIT -> no second ctrl_avalid until port 1 completes; port 0 issued from the next S_IDLE.
- Reset mid-op: not_reset low during S_WAIT -> all outputs 0 asynchronously. After release, a pending req1 alone is granted.
- RAM_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=20, ctrl_ack withheld -> timeout_err and req0_ack pulse together at cycle 20 of S_WAIT. A ctrl_ack 5 cycles later has no effect.

Source files
------------

// File: rtl/ram_arb_pkg.sv
// Shared encodings for the two-port RAM arbiter: FSM states and requester port IDs.
package ram_arb_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } arb_state_t;

    localparam logic PORT_ICACHE = 1'b0;
    localparam logic PORT_DCACHE = 1'b1;

endpackage

// File: rtl/ram_port_arbiter_if.sv
// Bundle of both cache request ports, the controller-side request and arbiter status.
interface ram_port_arbiter_if #(
    parameter int ADDR_SIZE       = 13,
    parameter int CACHE_STR_WIDTH = 64
);
    logic                       req0_avalid;
    logic [ADDR_SIZE-1:0]       req0_addr;
    logic                       req0_rnw;
    logic [CACHE_STR_WIDTH-1:0] req0_wdata;
    logic                       req0_ack;

    logic                       req1_avalid;
    logic [ADDR_SIZE-1:0]       req1_addr;
    logic                       req1_rnw;
    logic [CACHE_STR_WIDTH-1:0] req1_wdata;
    logic                       req1_ack;

    logic                       ctrl_avalid;
    logic [ADDR_SIZE-1:0]       ctrl_addr;
    logic                       ctrl_rnw;
    logic [CACHE_STR_WIDTH-1:0] ctrl_wdata;
    logic                       ctrl_ack;

    logic                       grant_id;
    logic                       busy;
    logic                       timeout_err;

    // Arbiter side.
    modport slave (
        input  req0_avalid, req0_addr, req0_rnw, req0_wdata,
        output req0_ack,
        input  req1_avalid, req1_addr, req1_rnw, req1_wdata,
        output req1_ack,
        output ctrl_avalid, ctrl_addr, ctrl_rnw, ctrl_wdata,
        input  ctrl_ack,
        output grant_id, busy, timeout_err
    );

    // Environment side: caches plus interface controller.
    modport master (
        output req0_avalid, req0_addr, req0_rnw, req0_wdata,
        input  req0_ack,
        output req1_avalid, req1_addr, req1_rnw, req1_wdata,
        input  req1_ack,
        input  ctrl_avalid, ctrl_addr, ctrl_rnw, ctrl_wdata,
        output ctrl_ack,
        input  grant_id, busy, timeout_err
    );

endinterface

// File: rtl/rr_arb2.sv
// Combinational two-way round-robin pick; a tie goes to the port that did not win last.
module rr_arb2
    import ram_arb_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic last_grant,
    output logic grant_valid,
    output logic grant_id
);

    always_comb begin
        grant_valid = req0 | req1;
        grant_id    = req1 ? PORT_DCACHE : PORT_ICACHE;
        if (req0 && req1)
            grant_id = ~last_grant;
    end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares one cache-to-RAM controller between the I-cache (port 0) and D-cache (port 1).
// Optional watchdog on the controller wait is enabled with `define RAM_ARB_TIMEOUT_EN.
module ram_port_arbiter
    import ram_arb_pkg::*;
#(
    parameter int ADDR_SIZE       = 13,
    parameter int CACHE_STR_WIDTH = 64,
    parameter int TIMEOUT_CYCLES  = 255
) (
    input logic               clk,
    input logic               not_reset,
    ram_port_arbiter_if.slave bus
);

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must lie in 1..255");
    end

    arb_state_t                 state, state_nxt;
    logic                       last_grant, last_grant_nxt;
    logic [ADDR_SIZE-1:0]       addr, addr_nxt;
    logic                       rnw, rnw_nxt;
    logic [CACHE_STR_WIDTH-1:0] wdata, wdata_nxt;
    logic                       avalid, avalid_nxt;
    logic                       ack0, ack0_nxt;
    logic                       ack1, ack1_nxt;
    logic                       gid, gid_nxt;
    logic                       busy, busy_nxt;
    logic                       pick_valid, pick_id;

`ifdef RAM_ARB_TIMEOUT_EN
    localparam logic [7:0] TMO_LIMIT = 8'(TIMEOUT_CYCLES);
    logic [7:0] wait_cnt, wait_cnt_nxt;
    logic       tmo, tmo_nxt;
`endif

    rr_arb2 u_rr (
        .req0       (bus.req0_avalid),
        .req1       (bus.req1_avalid),
        .last_grant (last_grant),
        .grant_valid(pick_valid),
        .grant_id   (pick_id)
    );

    always_comb begin
        state_nxt      = state;
        last_grant_nxt = last_grant;
        addr_nxt       = addr;
        rnw_nxt        = rnw;
        wdata_nxt      = wdata;
        avalid_nxt     = 1'b0;
        ack0_nxt       = 1'b0;
        ack1_nxt       = 1'b0;
        gid_nxt        = gid;
        busy_nxt       = busy;
`ifdef RAM_ARB_TIMEOUT_EN
        wait_cnt_nxt   = wait_cnt;
        tmo_nxt        = 1'b0;
`endif
        case (state)
            S_IDLE: begin
                if (pick_valid) begin
                    state_nxt      = S_ISSUE;
                    gid_nxt        = pick_id;
                    last_grant_nxt = pick_id;
                    busy_nxt       = 1'b1;
                    avalid_nxt     = 1'b1;
                    addr_nxt       = pick_id ? bus.req1_addr  : bus.req0_addr;
                    rnw_nxt        = pick_id ? bus.req1_rnw   : bus.req0_rnw;
                    wdata_nxt      = pick_id ? bus.req1_wdata : bus.req0_wdata;
                end
            end
            S_ISSUE: begin
                state_nxt = S_WAIT;
`ifdef RAM_ARB_TIMEOUT_EN
                wait_cnt_nxt = 8'd0;
`endif
            end
            S_WAIT: begin
                if (bus.ctrl_ack) begin
                    state_nxt = S_RESP;
                    ack0_nxt  = (gid == PORT_ICACHE);
                    ack1_nxt  = (gid == PORT_DCACHE);
                end
`ifdef RAM_ARB_TIMEOUT_EN
                // S_WAIT lasts exactly TMO_LIMIT cycles when the controller never answers.
                else if (wait_cnt + 8'd1 == TMO_LIMIT) begin
                    state_nxt = S_RESP;
                    ack0_nxt  = (gid == PORT_ICACHE);
                    ack1_nxt  = (gid == PORT_DCACHE);
                    tmo_nxt   = 1'b1;
                end else begin
                    wait_cnt_nxt = wait_cnt + 8'd1;
                end
`endif
            end
            S_RESP: begin
                state_nxt = S_IDLE;
                busy_nxt  = 1'b0;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge not_reset) begin
        if (!not_reset) begin
            state      <= S_IDLE;
            last_grant <= PORT_DCACHE;
            addr       <= '0;
            rnw        <= 1'b0;
            wdata      <= '0;
            avalid     <= 1'b0;
            ack0       <= 1'b0;
            ack1       <= 1'b0;
            gid        <= 1'b0;
            busy       <= 1'b0;
`ifdef RAM_ARB_TIMEOUT_EN
            wait_cnt   <= 8'd0;
            tmo        <= 1'b0;
`endif
        end else begin
            state      <= state_nxt;
            last_grant <= last_grant_nxt;
            addr       <= addr_nxt;
            rnw        <= rnw_nxt;
            wdata      <= wdata_nxt;
            avalid     <= avalid_nxt;
            ack0       <= ack0_nxt;
            ack1       <= ack1_nxt;
            gid        <= gid_nxt;
            busy       <= busy_nxt;
`ifdef RAM_ARB_TIMEOUT_EN
            wait_cnt   <= wait_cnt_nxt;
            tmo        <= tmo_nxt;
`endif
        end
    end

    assign bus.ctrl_avalid = avalid;
    assign bus.ctrl_addr   = addr;
    assign bus.ctrl_rnw    = rnw;
    assign bus.ctrl_wdata  = wdata;
    assign bus.req0_ack    = ack0;
    assign bus.req1_ack    = ack1;
    assign bus.grant_id    = gid;
    assign bus.busy        = busy;
`ifdef RAM_ARB_TIMEOUT_EN
    assign bus.timeout_err = tmo;
`else
    assign bus.timeout_err = 1'b0;
`endif

endmodule
